// File: rtl/lut_eval_seq.sv
// ---------------------------------------------------------------------------
// lut_eval_seq
//
// Evaluates a boolean function held as a 2**N_IN-entry truth table. A vector
// offered on in_bits/in_valid is looked up and the one-bit result is
// registered on out/out_valid one cycle later. A new table can be shifted in
// serially (cfg_start, then cfg_valid/cfg_bit, first bit = table MSB) without
// disturbing the table in use until the last bit arrives.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer keeps valid and its data stable until that edge; the
// consumer may raise or drop ready at any time. Ready never depends on valid.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, wins over every other input
//   in_valid   : input vector offered
//   in_bits    : input vector, in_bits[N_IN-1] is the index MSB
//   in_ready   : vector accepted this cycle if in_valid is also high
//   out_valid  : a result is held on out
//   out        : evaluated result
//   out_ready  : downstream consumes out this cycle if out_valid is also high
//   cfg_start  : request to reload the table (honoured in RUN only)
//   cfg_valid  : cfg_bit is valid this cycle (honoured in LOAD only)
//   cfg_bit    : serial table bit
//   cfg_done   : one-cycle pulse when a newly loaded table is committed
//   loading    : high while in LOAD; this is the FSM state as seen from outside
//   eval_count : number of accepted evaluations, wraps at 16 bits
// ---------------------------------------------------------------------------
module lut_eval_seq #(
   parameter int unsigned         N_IN        = 3,
   parameter logic [2**N_IN-1:0]  RESET_TABLE = 'hB9
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [N_IN-1:0] in_bits,
   output logic            in_ready,
   output logic            out_valid,
   output logic            out,
   input  logic            out_ready,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_done,
   output logic            loading,
   output logic [15:0]     eval_count
);

   localparam int unsigned T  = 2**N_IN;
   // The bit counter has to reach T-1, so one extra bit over N_IN is plenty.
   localparam int unsigned CW = N_IN + 1;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t          state_q;
   logic [T-1:0]    table_q;
   logic [T-1:0]    shadow_q;
   logic [CW-1:0]   cnt_q;
   logic            out_q;
   logic            out_valid_q;
   logic            cfg_done_q;
   logic [15:0]     eval_count_q;

   logic            accept;
   logic [N_IN-1:0] tbl_idx;
   logic            result_d;
   logic [T-1:0]    shadow_d;
   logic            last_bit;
   logic [CW-1:0]   cnt_d;
   logic [15:0]     eval_count_d;

   always_comb begin
      // The output register can take a new result when it is empty or is
      // being emptied this very cycle, which gives one result per cycle.
      in_ready     = (state_q == RUN) && (!out_valid_q || out_ready);
      accept       = in_valid && in_ready;
      // Table MSB belongs to input all-zeros: entry T-1-idx, which is ~idx.
      tbl_idx      = ~in_bits;
      result_d     = table_q[tbl_idx];
      shadow_d     = {shadow_q[T-2:0], cfg_bit};
      last_bit     = (cnt_q == CW'(T - 1));
      cnt_d        = cnt_q + CW'(1);
      eval_count_d = eval_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         table_q      <= RESET_TABLE;
         shadow_q     <= '0;
         cnt_q        <= '0;
         out_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         cfg_done_q   <= 1'b0;
         eval_count_q <= 16'd0;
      end else begin
         cfg_done_q <= 1'b0;

         // Result path runs in both states so a pending result can drain
         // while a new table is loading.
         if (accept) begin
            out_q        <= result_d;
            out_valid_q  <= 1'b1;
            eval_count_q <= eval_count_d;
         end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
         end

         case (state_q)
            RUN: begin
               if (cfg_start) begin
                  state_q  <= LOAD;
                  cnt_q    <= '0;
                  shadow_q <= '0;
               end
            end
            LOAD: begin
               // The live table only changes once the full image is present,
               // so an unfinished load never corrupts it.
               if (cfg_valid) begin
                  shadow_q <= shadow_d;
                  cnt_q    <= cnt_d;
                  if (last_bit) begin
                     table_q    <= shadow_d;
                     cfg_done_q <= 1'b1;
                     state_q    <= RUN;
                  end
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out        = out_q;
   assign cfg_done   = cfg_done_q;
   assign loading    = (state_q == LOAD);
   assign eval_count = eval_count_q;

endmodule

// File: tb/tb_lut_eval_seq.sv
module tb_lut_eval_seq;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance (N_IN = 3, table 0xB9)
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_bits = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out;
  logic       out_ready = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_done;
  logic       loading;
  logic [15:0] eval_count;

  lut_eval_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bits    (in_bits),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out        (out),
    .out_ready  (out_ready),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_done   (cfg_done),
    .loading    (loading),
    .eval_count (eval_count)
  );

  // Wide instance (N_IN = 4, table 0x8000) for the one-hot table and wrap
  logic        rst2 = 1'b1;
  logic        in_valid2 = 1'b0;
  logic [3:0]  in_bits2 = 4'd0;
  logic        in_ready2;
  logic        out_valid2;
  logic        out2;
  logic        cfg_done2;
  logic        loading2;
  logic [15:0] eval_count2;

  lut_eval_seq #(.N_IN(4), .RESET_TABLE(16'h8000)) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .in_valid   (in_valid2),
    .in_bits    (in_bits2),
    .in_ready   (in_ready2),
    .out_valid  (out_valid2),
    .out        (out2),
    .out_ready  (1'b1),
    .cfg_start  (1'b0),
    .cfg_valid  (1'b0),
    .cfg_bit    (1'b0),
    .cfg_done   (cfg_done2),
    .loading    (loading2),
    .eval_count (eval_count2)
  );

  // ---------------------------------------------------------------- bookkeeping
  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Hand-computed truth tables, listed for inputs 0..7
  logic exp_b9 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_69 [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // ---------------------------------------------------------------- scoreboard
  logic [0:0] exp_q[$];
  int         acc_q[$];
  int         exp_count = 0;
  int         last_acc = 0;
  int         done_cnt = 0;
  logic       fresh = 1'b1;
  logic       done2 = 1'b0;

  task automatic note_accept(input logic exp_out);
    exp_q.push_back(exp_out);
    acc_q.push_back(cyc);
    exp_count++;
    last_acc = cyc;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      fresh = 1'b1;
    end else begin
      if (cfg_done) done_cnt++;
      if (loading) check("in_ready_during_load", 32'(in_ready), 32'd0);
      // First cycle a result is shown must be one cycle after acceptance.
      if (out_valid && fresh) begin
        if (acc_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else check("latency", 32'(cyc), 32'(acc_q.pop_front() + 1));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_consume", 32'd1, 32'd0);
        else check("out_value", 32'(out), 32'(exp_q.pop_front()));
      end
      fresh = !out_valid || out_ready;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [2:0] bits, input logic exp_out);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    else note_accept(exp_out);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_begin();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic cfg_send_bit(input logic b, input int gap, input logic also_start);
    cfg_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    cfg_start = also_start;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_eval_count", 32'(eval_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    exp_count = 0;
  endtask

  // ---------------------------------------------------------------- main flow
  initial begin
    logic [7:0] pat;
    int t0;
    int d0;

    @(posedge clk); #1;
    apply_reset();
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Stream 0..7 through the reset table back to back.
    out_ready = 1'b1;
    send(3'd0, exp_b9[0]);
    t0 = last_acc;
    for (int i = 1; i < 8; i++) send(3'(i), exp_b9[i]);
    check("throughput", 32'(last_acc - t0), 32'd7);
    @(negedge clk);
    check("eval_count_8", 32'(eval_count), 32'd8);
    @(posedge clk); #1;

    // Stall downstream with a result held, then release.
    out_ready = 1'b0;
    send(3'd0, 1'b1);
    in_valid = 1'b1;
    in_bits  = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out", 32'(out), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_consume", 32'(out_valid), 32'd1);
    if (in_ready) note_accept(exp_b9[1]);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Load 0x69 with gaps; a cfg_start mid-load must be ignored.
    pat = 8'h69;
    d0  = done_cnt;
    cfg_begin();
    @(negedge clk);
    check("load_entry_loading", 32'(loading), 32'd1);
    @(posedge clk); #1;
    for (int i = 7; i >= 0; i--)
      cfg_send_bit(pat[i], (i % 2 == 1) ? 1 : int'($urandom_range(0, 2)), (i == 3));
    @(negedge clk);
    check("load_cfg_done", 32'(cfg_done), 32'd1);
    check("load_exit_loading", 32'(loading), 32'd0);
    repeat (3) @(negedge clk);
    check("load_done_pulses", 32'(done_cnt - d0), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(3'(i), exp_69[i]);

    // Partial load interrupted by reset restores the reset table.
    cfg_begin();
    for (int i = 0; i < 4; i++) cfg_send_bit(1'b0, 0, 1'b0);
    apply_reset();
    send(3'b110, 1'b0);
    send(3'b000, 1'b1);

    // cfg_valid while running is ignored.
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) cfg_send_bit(1'b0, 0, 1'b0);
    @(negedge clk);
    check("run_cfg_ignored_loading", 32'(loading), 32'd0);
    check("run_cfg_ignored_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;
    send(3'b000, 1'b1);

    // cfg_start and an input in the same cycle: input uses the old table.
    in_valid  = 1'b1;
    in_bits   = 3'b001;
    cfg_start = 1'b1;
    @(negedge clk);
    check("same_cycle_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) note_accept(1'b0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    in_bits   = 3'b010;
    for (int i = 0; i < 8; i++) cfg_send_bit(1'b1, int'($urandom_range(0, 1)), 1'b0);
    send(3'b010, 1'b1);

    repeat (3) @(negedge clk);
    check("eval_count_total", 32'(eval_count), 32'(exp_count));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 100000 && !done2; i++) @(posedge clk);
    check("wide_instance_done", 32'(done2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------- wide instance
  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("w_rst_eval_count", 32'(eval_count2), 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    in_valid2 = 1'b1;
    for (int k = 0; k <= 65536; k++) begin
      in_bits2 = 4'(k);
      @(negedge clk);
      if (k >= 1 && k <= 16) begin
        check("w_in_ready", 32'(in_ready2), 32'd1);
        check("w_out_valid", 32'(out_valid2), 32'd1);
        check("w_out", 32'(out2), (k == 1) ? 32'd1 : 32'd0);
      end
      if (k == 65535) check("w_eval_count_ffff", 32'(eval_count2), 32'h0000ffff);
      if (k == 65536) check("w_eval_count_wrap", 32'(eval_count2), 32'd0);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    done2 = 1'b1;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lut_eval_seq.md
LUT_EVAL_SEQ -- requirements
Module: lut_eval_seq

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of truth-table inputs, legal range 1..6.
REQ-002 SHALL have parameter RESET_TABLE, default 'hB9, width 2**N_IN: truth table loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input vector offered.
REQ-006 SHALL have port in_bits  input  N_IN  input vector; in_bits[N_IN-1] is the most significant bit of the index.
REQ-007 SHALL have port in_ready  output  1  input vector accepted this cycle when in_valid is also high.
REQ-008 SHALL have port out_valid  output  1  result held in out.
REQ-009 SHALL have port out  output  1  evaluated result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out this cycle when out_valid is also high.
REQ-011 SHALL have port cfg_start  input  1  request to reload the table.
REQ-012 SHALL have port cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-013 SHALL have port cfg_bit  input  1  serial table bit.
REQ-014 SHALL have port cfg_done  output  1  one-cycle pulse when a new table is committed.
REQ-015 SHALL have port loading  output  1  high while in LOAD.
REQ-016 SHALL have port eval_count  output  16  count of accepted evaluations.

Function
REQ-017 SHALL define T = 2**N_IN and idx = unsigned in_bits; result = table[T-1-idx], so the table MSB gives the output for input all-zeros.
REQ-018 SHALL implement states RUN and LOAD.
REQ-019 in_ready SHALL be high iff state==RUN and (out_valid==0 or out_ready==1).
REQ-020 on in_valid&&in_ready, out SHALL register the result and out_valid SHALL be 1 in the next cycle (latency 1); full throughput of one result per cycle.
REQ-021 out_valid SHALL clear on out_valid&&out_ready unless a new input is accepted in the same cycle.
REQ-022 out and out_valid SHALL hold stable while out_valid==1 and out_ready==0.
REQ-023 cfg_start in RUN SHALL move to LOAD next cycle and clear the bit counter and the shadow register.
REQ-024 an input accepted in the same cycle as cfg_start SHALL be evaluated with the old table.
REQ-025 in LOAD, each cycle with cfg_valid SHALL shift: shadow <= {shadow[T-2:0], cfg_bit}, and the counter SHALL increment; the first bit received becomes the table MSB.
REQ-026 on the T-th cfg_valid bit, the table SHALL take the completed shadow value, cfg_done SHALL pulse in the next cycle, and state SHALL return to RUN in that same next cycle.
REQ-027 cfg_start in LOAD SHALL be ignored; cfg_valid in RUN SHALL be ignored.
REQ-028 a result pending at LOAD entry SHALL remain valid and may drain during LOAD.
REQ-029 eval_count SHALL increment by 1 per accepted input and wrap from 0xFFFF to 0.
REQ-030 the table SHALL be unchanged by a partial load.

Reset
REQ-031 while rst is high, in any state including mid-LOAD: state=RUN, table=RESET_TABLE, shadow=0, counter=0, out_valid=0, out=0, cfg_done=0, loading=0, eval_count=0.
REQ-032 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-033 Bench SHALL reset with default parameters, stream inputs 0..7 with out_ready=1 -> out = 1,0,1,1,1,0,0,1, each one cycle after acceptance, and eval_count=8.
REQ-034 Bench SHALL hold out_ready=0 after one accepted input -> in_ready=0, out stable; on release, the next input is accepted in the same cycle the result is consumed.
REQ-035 Bench SHALL pulse cfg_start, then send 8 bits 0,1,1,0,1,0,0,1 (0x69) with gaps in cfg_valid -> cfg_done pulses once and inputs 0..7 give 0,1,1,0,1,0,0,1.
REQ-036 Bench SHALL assert rst after 4 of 8 config bits -> loading=0, table restored to 0xB9, and input 3'b110 gives 0.
REQ-037 Bench SHALL assert cfg_start and in_valid with in_bits=3'b001 in the same cycle -> out=0 from the old table, and in_ready=0 until cfg_done.
REQ-038 Bench SHALL set N_IN=4, RESET_TABLE='h8000 -> out=1 only for in_bits=4'b0000; eval_count wraps 0xFFFF->0.
